// File: rtl/ob_feed_arbiter_if.sv
// Order-book feed arbiter bus: FWFT FIFO read port, local command port and order-book issue port.
// Handshakes: cmd_valid/cmd_data held by the requester until cmd_ready (same cycle = accepted);
// feed_rd_en pops the FIFO head; ob_input_valid is a one-cycle strobe qualifying ob_input_data.
interface ob_feed_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] feed_dout;
  logic              feed_empty;
  logic              feed_rd_en;
  logic              cmd_valid;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              ob_engine_busy;
  logic              ob_input_valid;
  logic [DATA_W-1:0] ob_input_data;
  logic              grant_cmd;

  modport master (
    input  feed_dout, feed_empty, cmd_valid, cmd_data, ob_engine_busy,
    output feed_rd_en, cmd_ready, ob_input_valid, ob_input_data, grant_cmd
  );

  modport slave (
    output feed_dout, feed_empty, cmd_valid, cmd_data, ob_engine_busy,
    input  feed_rd_en, cmd_ready, ob_input_valid, ob_input_data, grant_cmd
  );
endinterface

// File: rtl/ob_feed_arbiter.sv
// Shares the order-book input between the market feed FIFO and a local command port,
// dropping null feed words, pacing issues against engine busy, with flush and saturating stats.
module ob_feed_arbiter #(
  parameter int DATA_W         = 32,
  parameter int MAX_FEED_BURST = 8,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  ob_feed_arbiter_if.master bus,
  output logic [CNT_W-1:0] stat_feed_words,
  output logic [CNT_W-1:0] stat_cmd_words,
  output logic [CNT_W-1:0] stat_null_words,
  output logic [CNT_W-1:0] stat_flushed,
  output logic [CNT_W-1:0] stat_stall_cycles,
  output logic [1:0]       dbg_state
);

  localparam int BW = $clog2(MAX_FEED_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_FEED_BURST);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ARB   = 2'd1,
    S_GUARD = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     burst_cnt;
  logic              feed_req, null_head, req_any, cmd_win;
  logic              issue_feed, issue_cmd, issue, null_pop, flush_pop, stall;
  logic              valid_q, grant_q;
  logic [DATA_W-1:0] data_q;

  assign feed_req  = !bus.feed_empty && (bus.feed_dout != '0);
  assign null_head = !bus.feed_empty && (bus.feed_dout == '0);
  assign req_any   = feed_req || bus.cmd_valid;
  // Feed wins unless the pending command has waited out a full feed burst.
  assign cmd_win   = bus.cmd_valid && (!feed_req || (burst_cnt == BURST_MAX));

  always_comb begin
    state_nxt  = state;
    issue_feed = 1'b0;
    issue_cmd  = 1'b0;
    null_pop   = 1'b0;
    flush_pop  = 1'b0;
    stall      = 1'b0;
    case (state)
      S_OFF: begin
        if (flush)       state_nxt = S_FLUSH;
        else if (enable) state_nxt = S_ARB;
      end
      S_ARB: begin
        null_pop = null_head;
        if (bus.ob_engine_busy) begin
          stall = req_any;
        end else if (req_any) begin
          issue_cmd  = cmd_win;
          issue_feed = !cmd_win;
        end
        if (flush)                       state_nxt = S_FLUSH;
        else if (!enable)                state_nxt = S_OFF;
        else if (issue_cmd || issue_feed) state_nxt = S_GUARD;
      end
      S_GUARD: begin
        // One dead cycle lets a busy raised by the last issue be seen first.
        null_pop = null_head;
        if (flush)        state_nxt = S_FLUSH;
        else if (!enable) state_nxt = S_OFF;
        else              state_nxt = S_ARB;
      end
      S_FLUSH: begin
        flush_pop = !bus.feed_empty;
        if (!flush) state_nxt = S_OFF;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  assign issue              = issue_feed || issue_cmd;
  assign bus.feed_rd_en     = issue_feed || null_pop || flush_pop;
  assign bus.cmd_ready      = issue_cmd;
  assign bus.ob_input_valid = valid_q;
  assign bus.ob_input_data  = data_q;
  assign bus.grant_cmd      = grant_q;
  assign dbg_state          = state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_OFF;
      burst_cnt         <= '0;
      valid_q           <= 1'b0;
      data_q            <= '0;
      grant_q           <= 1'b0;
      stat_feed_words   <= '0;
      stat_cmd_words    <= '0;
      stat_null_words   <= '0;
      stat_flushed      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= issue;
      if (issue) begin
        data_q  <= issue_cmd ? bus.cmd_data : bus.feed_dout;
        grant_q <= issue_cmd;
      end
      // Only feed issues made while a command waits count toward the burst.
      if (!bus.cmd_valid || issue_cmd) burst_cnt <= '0;
      else if (issue_feed)             burst_cnt <= burst_cnt + BW'(1);
      stat_feed_words   <= sat_inc(stat_feed_words, issue_feed);
      stat_cmd_words    <= sat_inc(stat_cmd_words, issue_cmd);
      stat_null_words   <= sat_inc(stat_null_words, null_pop);
      stat_flushed      <= sat_inc(stat_flushed, flush_pop);
      stat_stall_cycles <= sat_inc(stat_stall_cycles, stall);
    end
  end

endmodule

// File: tb/tb_ob_feed_arbiter.sv
// Bench for ob_feed_arbiter: vector table, directed multi-cycle sequences and a randomized
// run checked against a stream-level model (word order, pacing, busy, burst and stat totals).
module tb_ob_feed_arbiter;
  localparam int DW  = 32;
  localparam int MAX = 4;
  localparam int CW  = 8;

  logic          clk, rst_n, enable, flush;
  logic [CW-1:0] stat_feed_words, stat_cmd_words, stat_null_words, stat_flushed, stat_stall_cycles;
  logic [1:0]    dbg_state;

  ob_feed_arbiter_if #(.DATA_W(DW)) bus ();

  ob_feed_arbiter #(.DATA_W(DW), .MAX_FEED_BURST(MAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .bus(bus.master),
    .stat_feed_words(stat_feed_words), .stat_cmd_words(stat_cmd_words),
    .stat_null_words(stat_null_words), .stat_flushed(stat_flushed),
    .stat_stall_cycles(stat_stall_cycles), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int errors = 0, checks = 0;
  logic [DW-1:0] fq[$];          // FIFO contents
  logic [DW-1:0] cmd_src_q[$];   // commands waiting to be presented
  logic [DW-1:0] exp_feed_q[$];  // nonzero feed words expected at the order book
  logic [DW-1:0] exp_cmd_q[$];   // accepted commands awaiting issue
  logic [DW-1:0] pulse_data[$];
  bit            pulse_grant[$];
  int            pulse_step[$];
  bit  hide, busy_drv, mon_en;
  bit  s_rd, s_rdy, s_busy, s_cmdv;
  int  stepn = 0, last_pulse = -100, pops = 0, rdy_cnt = 0, feed_run = 0;
  int  m_feed = 0, m_cmd = 0, m_null = 0, m_flushed = 0, m_stall = 0;

  function automatic int sat(input int n);
    return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", name, act, exp, stepn);
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_feed"},  stat_feed_words,   sat(m_feed));
    check({tag, "_stat_cmd"},   stat_cmd_words,    sat(m_cmd));
    check({tag, "_stat_null"},  stat_null_words,   sat(m_null));
    check({tag, "_stat_flush"}, stat_flushed,      sat(m_flushed));
    check({tag, "_stat_stall"}, stat_stall_cycles, sat(m_stall));
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    if (w != '0) exp_feed_q.push_back(w);
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    if (fq.size() > 0 && !hide) begin
      bus.feed_empty = 1'b0; bus.feed_dout = fq[0];
    end else begin
      bus.feed_empty = 1'b1; bus.feed_dout = $urandom;
    end
    if (cmd_src_q.size() > 0) begin
      bus.cmd_valid = 1'b1; bus.cmd_data = cmd_src_q[0];
    end else begin
      bus.cmd_valid = 1'b0; bus.cmd_data = $urandom;
    end
    bus.ob_engine_busy = busy_drv;
  endtask

  // One clock: drive after negedge, sample handshakes, update FIFO/cmd models at posedge,
  // then check the registered issue port at the following negedge.
  task automatic step();
    bit had_head;
    logic [DW-1:0] w;
    drive_inputs();
    #1;
    s_rd = bus.feed_rd_en; s_rdy = bus.cmd_ready;
    s_busy = bus.ob_engine_busy; s_cmdv = bus.cmd_valid;
    had_head = !bus.feed_empty;
    @(posedge clk);
    if (s_rd) begin
      check("pop_needs_head", had_head, 1'b1);
      if (had_head) begin w = fq.pop_front(); pops++; end
    end
    if (s_rdy) begin
      check("ready_needs_valid", s_cmdv, 1'b1);
      if (s_cmdv) exp_cmd_q.push_back(cmd_src_q.pop_front());
      rdy_cnt++;
    end
    @(negedge clk);
    if (bus.ob_input_valid) begin
      pulse_data.push_back(bus.ob_input_data);
      pulse_grant.push_back(bus.grant_cmd);
      pulse_step.push_back(stepn);
      if (mon_en) begin
        check("pulse_gap_ge2", (stepn - last_pulse) >= 2, 1'b1);
        check("issue_while_busy", s_busy, 1'b0);
        if (bus.grant_cmd) begin
          feed_run = 0;
          if (exp_cmd_q.size() == 0) check("unexpected_cmd_issue", bus.ob_input_data, 0);
          else check("cmd_issue_data", bus.ob_input_data, exp_cmd_q.pop_front());
        end else begin
          feed_run = s_cmdv ? feed_run + 1 : 0;
          check("feed_burst_len_ok", feed_run <= MAX, 1'b1);
          if (exp_feed_q.size() == 0) check("unexpected_feed_issue", bus.ob_input_data, 0);
          else check("feed_issue_data", bus.ob_input_data, exp_feed_q.pop_front());
        end
      end
      last_pulse = stepn;
    end
    stepn++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_pulses();
    pulse_data.delete(); pulse_grant.delete(); pulse_step.delete();
    pops = 0; rdy_cnt = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((fq.size() > 0 || cmd_src_q.size() > 0 || exp_feed_q.size() > 0 ||
            exp_cmd_q.size() > 0) && n < budget) begin
      step(); n++;
    end
    check({tag, "_drained_in_budget"}, n < budget, 1'b1);
    run(3);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, bus.ob_input_valid, 1'b0);
    check({tag, "_rst_data"},  bus.ob_input_data, 0);
    check({tag, "_rst_grant"}, bus.grant_cmd, 1'b0);
    check({tag, "_rst_rd_en"}, bus.feed_rd_en, 1'b0);
    check({tag, "_rst_ready"}, bus.cmd_ready, 1'b0);
    check({tag, "_rst_state"}, dbg_state, 2'd0);
    m_feed = 0; m_cmd = 0; m_null = 0; m_flushed = 0; m_stall = 0;
    check_stats(tag);
    @(negedge clk);
    rst_n = 1'b1;
    last_pulse = -100; feed_run = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            feed_present;
    logic [DW-1:0] feed_word;
    bit            cmd_v;
    logic [DW-1:0] cmd_word;
    bit            busy;
    bit            exp_rd;
    bit            exp_rdy;
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    bit            exp_grant;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [DW-1:0] w;
    bit exp_g[6];
    int drop_step, n_rem, c_rem, nz_cnt, z_cnt, c_cnt;

    vecs[0] = '{1, 32'h11223344, 0, 32'h0,        0, 1, 0, 1, 32'h11223344, 0};
    vecs[1] = '{0, 32'h0,        1, 32'hC0DE0001, 0, 0, 1, 1, 32'hC0DE0001, 1};
    vecs[2] = '{1, 32'hA5A5A5A5, 1, 32'h0BAD0002, 0, 1, 0, 1, 32'hA5A5A5A5, 0};
    vecs[3] = '{1, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'hA5A5A5A5, 0};
    vecs[4] = '{1, 32'h0,        1, 32'h12345678, 0, 1, 1, 1, 32'h12345678, 1};
    vecs[5] = '{1, 32'h00000077, 0, 32'h0,        1, 0, 0, 0, 32'h12345678, 1};
    vecs[6] = '{0, 32'h0,        1, 32'h0FEDCBA9, 1, 0, 0, 0, 32'h12345678, 1};
    vecs[7] = '{0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h12345678, 1};
    vecs[8] = '{1, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h12345678, 1};
    vecs[9] = '{1, 32'h80000000, 1, 32'h00000001, 0, 1, 0, 1, 32'h80000000, 0};

    rst_n = 1'b0; enable = 1'b0; flush = 1'b0;
    hide = 0; busy_drv = 0; mon_en = 0;
    drive_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", bus.ob_input_valid, 1'b0);
    check("reset_rd_en", bus.feed_rd_en, 1'b0);
    check("reset_ready", bus.cmd_ready, 1'b0);
    check("reset_state", dbg_state, 2'd0);
    check_stats("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // enable: S_OFF -> S_ARB
    enable = 1'b1;
    step();
    check("enable_to_arb", dbg_state, 2'd1);

    // ---- table-driven single-cycle vectors, each started from S_ARB ----
    for (int i = 0; i < 10; i++) begin
      fq.delete(); cmd_src_q.delete();
      if (vecs[i].feed_present) fq.push_back(vecs[i].feed_word);
      if (vecs[i].cmd_v) cmd_src_q.push_back(vecs[i].cmd_word);
      busy_drv = vecs[i].busy;
      step();
      check($sformatf("vec%0d_rd_en", i), s_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_cmd_ready", i), s_rdy, vecs[i].exp_rdy);
      check($sformatf("vec%0d_valid", i), bus.ob_input_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_data", i), bus.ob_input_data, vecs[i].exp_data);
      check($sformatf("vec%0d_grant", i), bus.grant_cmd, vecs[i].exp_grant);
      fq.delete(); cmd_src_q.delete(); exp_cmd_q.delete();
      busy_drv = 0;
      step();
    end
    m_feed = 3; m_cmd = 2; m_null = 3; m_stall = 2;
    check_stats("table");

    // ---- two feed words, back to back ----
    mon_en = 1; clear_pulses();
    push_word(32'h11223344); push_word(32'h55667788);
    run(6);
    check("seq1_pulses", pulse_data.size(), 2);
    if (pulse_data.size() == 2) begin
      check("seq1_spacing", pulse_step[1] - pulse_step[0], 2);
      check("seq1_grant0", pulse_grant[0], 1'b0);
      check("seq1_grant1", pulse_grant[1], 1'b0);
    end
    m_feed += 2;
    check_stats("seq1");

    // ---- null word in the middle of the stream ----
    clear_pulses();
    push_word(32'hAAAA0001); push_word(32'h0); push_word(32'hAAAA0002);
    run(8);
    check("seq2_pulses", pulse_data.size(), 2);
    check("seq2_pops", pops, 3);
    m_feed += 2; m_null += 1;
    check_stats("seq2");

    // ---- feed burst limit with a command held ----
    clear_pulses();
    for (int i = 0; i < 10; i++) push_word(32'hF0000000 + i);
    cmd_src_q.push_back(32'hC0DE0001);
    run(26);
    exp_g = '{0, 0, 0, 0, 1, 0};
    check("seq3_pulses", pulse_data.size(), 11);
    if (pulse_data.size() >= 6)
      for (int i = 0; i < 6; i++) check($sformatf("seq3_grant%0d", i), pulse_grant[i], exp_g[i]);
    check("seq3_cmd_ready_once", rdy_cnt, 1);
    m_feed += 10; m_cmd += 1;
    check_stats("seq3");

    // ---- busy for 10 cycles with a word waiting ----
    clear_pulses();
    push_word(32'hBEEF0001);
    busy_drv = 1;
    run(10);
    check("seq4_no_issue_busy", pulse_data.size(), 0);
    check("seq4_word_held", fq.size(), 1);
    drop_step = stepn;
    busy_drv = 0;
    run(3);
    check("seq4_pulses", pulse_data.size(), 1);
    if (pulse_data.size() == 1) check("seq4_first_issue_step", pulse_step[0], drop_step);
    m_feed += 1; m_stall += 10;
    check_stats("seq4");

    // ---- flush of 5 words (one zero) from S_OFF with a command pending ----
    enable = 1'b0;
    run(2);
    check("seq5_off", dbg_state, 2'd0);
    clear_pulses();
    push_word(32'h51); push_word(32'h52); push_word(32'h0); push_word(32'h54); push_word(32'h55);
    cmd_src_q.push_back(32'hDEAD0005);
    flush = 1'b1;
    run(7);
    check("seq5_state_flush", dbg_state, 2'd3);
    check("seq5_pops", pops, 5);
    check("seq5_fifo_empty", fq.size(), 0);
    check("seq5_no_issue", pulse_data.size(), 0);
    check("seq5_no_ready", rdy_cnt, 0);
    cmd_src_q.delete(); exp_feed_q.delete();
    enable = 1'b1;
    flush = 1'b0;
    step();
    check("seq5_off_after_flush", dbg_state, 2'd0);
    step();
    check("seq5_arb_after_off", dbg_state, 2'd1);
    m_flushed += 5;
    check_stats("seq5");

    // ---- async reset mid-stream and mid-burst ----
    for (int i = 0; i < 6; i++) push_word(32'h60000000 + i);
    cmd_src_q.push_back(32'hC0DE0006);
    run(3);
    async_reset("seq6");
    clear_pulses();
    n_rem = exp_feed_q.size(); c_rem = cmd_src_q.size();
    step();
    check("seq6_off_to_arb", dbg_state, 2'd1);
    check("seq6_no_issue_in_off", pulse_data.size(), 0);
    step();
    check("seq6_resume_issue", pulse_data.size(), 1);
    drain("seq6", 60);
    check("seq6_total_pulses", pulse_data.size(), n_rem + c_rem);
    m_feed = n_rem; m_cmd = c_rem;
    check_stats("seq6");

    // ---- randomized traffic against the stream model ----
    async_reset("rnd");
    fq.delete(); cmd_src_q.delete(); exp_feed_q.delete(); exp_cmd_q.delete();
    nz_cnt = 0; z_cnt = 0; c_cnt = 0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          w = '0; z_cnt++;
        end else begin
          w = $urandom; if (w == '0) w = 32'h1; nz_cnt++;
        end
        push_word(w);
      end
      if (cmd_src_q.size() == 0 && $urandom_range(0, 11) == 0) begin
        w = $urandom; cmd_src_q.push_back(w); c_cnt++;
      end
      busy_drv = ($urandom_range(0, 3) == 0);
      hide = ($urandom_range(0, 7) == 0);
      step();
    end
    busy_drv = 0; hide = 0;
    drain("rnd", 3000);
    m_feed = nz_cnt; m_null = z_cnt; m_cmd = c_cnt; m_flushed = 0;
    check("rnd_stat_feed",  stat_feed_words, sat(m_feed));
    check("rnd_stat_cmd",   stat_cmd_words,  sat(m_cmd));
    check("rnd_stat_null",  stat_null_words, sat(m_null));
    check("rnd_stat_flush", stat_flushed,    0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
